tlb_op_ctrl: RTL

Sequencer for the TLB management instructions TLBP, TLBR, TLBWI and TLBWR.
- Accepts one operation at a time from the writeback stage and latches the CP0 EntryHi/EntryLo0/EntryLo1/Index operands.
- Drives the TLB's search port 1, read port and write port, and owns the Random register.
- Returns a one-cycle result pulse that CP0 uses to update Index, EntryHi, EntryLo0 and EntryLo1.

---
 rtl/tlb_op_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBP/TLBR/TLBWI/TLBWR.
// Each accepted op runs IDLE -> EXEC -> DONE. The TLB ports are driven in EXEC from operands latched at accept.
// A one-cycle done pulse then carries the result back to CP0. The block also owns the free-running Random register.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    output logic            op_ready,
    input  logic [26:0]     cp0_hi,
    input  logic [25:0]     cp0_lo0,
    input  logic [25:0]     cp0_lo1,
    input  logic [IDXW-1:0] cp0_index,
    output logic [IDXW-1:0] random,
    output logic [18:0]     tlb_s_vpn2,
    output logic            tlb_s_odd,
    output logic [7:0]      tlb_s_asid,
    input  logic            tlb_s_found,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic [26:0]     tlb_r_hi,
    input  logic            tlb_r_g,
    input  logic [24:0]     tlb_r_lo0,
    input  logic [24:0]     tlb_r_lo1,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [26:0]     tlb_w_hi,
    output logic            tlb_w_g,
    output logic [24:0]     tlb_w_lo0,
    output logic [24:0]     tlb_w_lo1,
    output logic            done,
    output logic [1:0]      done_type,
    output logic            p_miss,
    output logic [IDXW-1:0] p_index,
    output logic [26:0]     rd_hi,
    output logic [25:0]     rd_lo0,
    output logic [25:0]     rd_lo1
);

    localparam int unsigned HI_W = 27;
    localparam int unsigned LO_W = 26;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [LO_W-1:0]   lo0_q, lo0_d;
    logic [LO_W-1:0]   lo1_q, lo1_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   rnd_snap_q, rnd_snap_d;
    logic [IDXW-1:0]   random_q, random_d;
    logic              done_q, done_d;
    logic [1:0]        done_type_q, done_type_d;
    logic              p_miss_q, p_miss_d;
    logic [IDXW-1:0]   p_index_q, p_index_d;
    logic [HI_W-1:0]   rd_hi_q, rd_hi_d;
    logic [LO_W-1:0]   rd_lo0_q, rd_lo0_d;
    logic [LO_W-1:0]   rd_lo1_q, rd_lo1_d;

    logic in_exec;
    logic sel_p;
    logic sel_r;
    logic sel_w;

    // Next-state, operand latching, Random countdown and result capture
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hi_d        = hi_q;
        lo0_d       = lo0_q;
        lo1_d       = lo1_q;
        idx_d       = idx_q;
        rnd_snap_d  = rnd_snap_q;
        done_d      = 1'b0;
        done_type_d = 2'd0;
        p_miss_d    = p_miss_q;
        p_index_d   = p_index_q;
        rd_hi_d     = rd_hi_q;
        rd_lo0_d    = rd_lo0_q;
        rd_lo1_d    = rd_lo1_q;
        random_d    = (random_q == '0) ? IDXW'(TLBNUM - 1) : random_q - IDXW'(1);

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    state_d    = S_EXEC;
                    op_d       = op_type;
                    hi_d       = cp0_hi;
                    lo0_d      = cp0_lo0;
                    lo1_d      = cp0_lo1;
                    idx_d      = cp0_index;
                    rnd_snap_d = random_q;
                end
            end
            S_EXEC: begin
                state_d     = S_DONE;
                done_d      = 1'b1;
                done_type_d = op_q;
                if (op_q == OP_TLBP) begin
                    p_miss_d  = ~tlb_s_found;
                    p_index_d = tlb_s_found ? tlb_s_index : '0;
                end
                if (op_q == OP_TLBR) begin
                    rd_hi_d  = tlb_r_hi;
                    rd_lo0_d = {tlb_r_lo0, tlb_r_g};
                    rd_lo1_d = {tlb_r_lo1, tlb_r_g};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            hi_q        <= '0;
            lo0_q       <= '0;
            lo1_q       <= '0;
            idx_q       <= '0;
            rnd_snap_q  <= '0;
            random_q    <= IDXW'(TLBNUM - 1);
            done_q      <= 1'b0;
            done_type_q <= 2'd0;
            p_miss_q    <= 1'b0;
            p_index_q   <= '0;
            rd_hi_q     <= '0;
            rd_lo0_q    <= '0;
            rd_lo1_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo0_q       <= lo0_d;
            lo1_q       <= lo1_d;
            idx_q       <= idx_d;
            rnd_snap_q  <= rnd_snap_d;
            random_q    <= random_d;
            done_q      <= done_d;
            done_type_q <= done_type_d;
            p_miss_q    <= p_miss_d;
            p_index_q   <= p_index_d;
            rd_hi_q     <= rd_hi_d;
            rd_lo0_q    <= rd_lo0_d;
            rd_lo1_q    <= rd_lo1_d;
        end
    end

    // TLB port drive: decoded from state and latched operands, zero outside the matching EXEC
    always_comb begin
        in_exec = (state_q == S_EXEC);
        sel_p   = in_exec && (op_q == OP_TLBP);
        sel_r   = in_exec && (op_q == OP_TLBR);
        sel_w   = in_exec && ((op_q == OP_TLBWI) || (op_q == OP_TLBWR));

        tlb_s_vpn2  = sel_p ? hi_q[26:8] : 19'd0;
        tlb_s_asid  = sel_p ? hi_q[7:0]  : 8'd0;
        tlb_s_odd   = 1'b0;
        tlb_r_index = sel_r ? idx_q : '0;

        // A reset sampled at the end of EXEC must also suppress the write
        tlb_we      = sel_w && !reset;
        tlb_w_index = sel_w ? ((op_q == OP_TLBWR) ? rnd_snap_q : idx_q) : '0;
        tlb_w_hi    = sel_w ? hi_q : '0;
        tlb_w_lo0   = sel_w ? lo0_q[25:1] : 25'd0;
        tlb_w_lo1   = sel_w ? lo1_q[25:1] : 25'd0;
        tlb_w_g     = sel_w && lo0_q[0] && lo1_q[0];
    end

    assign op_ready  = (state_q == S_IDLE);
    assign random    = random_q;
    assign done      = done_q;
    assign done_type = done_type_q;
    assign p_miss    = p_miss_q;
    assign p_index   = p_index_q;
    assign rd_hi     = rd_hi_q;
    assign rd_lo0    = rd_lo0_q;
    assign rd_lo1    = rd_lo1_q;

endmodule
